gsm_mul_pipe: RTL and testbench

Parametrised, pipelined multiplier for the GSM datapath. It is the next generation of the fixed 16s×15u combinational multiplier. Width, pipeline depth and per-operand signedness are all configurable, and the signedness is selectable per transaction. It adds clock-enable stalling, a valid pipeline and an arithmetic post-shift, and can optionally saturate the narrowed output. It sits between the HLS-scheduled operand registers and the accumulate/LPC stages, replacing per-site `mul_*` instances.

---
 rtl/gsm_mul_pkg.sv | 20 ++
 rtl/gsm_mul_core.sv | 28 ++
 rtl/gsm_mul_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_gsm_mul_pipe.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsm_mul_pkg.sv
// Shared definitions for the GSM pipelined multiplier: mode encodings, product
// width helper and the legal pipeline-depth range.
package gsm_mul_pkg;

    // mode[0] selects signed din0, mode[1] selects signed din1
    localparam logic [1:0] GSM_MUL_UU = 2'b00;
    localparam logic [1:0] GSM_MUL_SU = 2'b01;
    localparam logic [1:0] GSM_MUL_US = 2'b10;
    localparam logic [1:0] GSM_MUL_SS = 2'b11;

    localparam int GSM_MUL_STAGE_MIN = 1;
    localparam int GSM_MUL_STAGE_MAX = 8;

    // Each operand gains one extension bit, so the signed product of the
    // extended operands is exact in this many bits for every mode.
    function automatic int gsm_mul_pw(input int w0, input int w1);
        return w0 + w1 + 2;
    endfunction

endpackage

// File: rtl/gsm_mul_core.sv
// Combinational extend-and-multiply: each operand is sign- or zero-extended by
// its mode bit, then the two are multiplied as signed values.
module gsm_mul_core
    import gsm_mul_pkg::*;
#(
    parameter int A_W = 16,
    parameter int B_W = 15
) (
    input  logic                      [A_W-1:0]     a,
    input  logic                      [B_W-1:0]     b,
    input  logic                      [1:0]         mode,
    output logic signed               [A_W+B_W+1:0] p
);

    localparam int PW = gsm_mul_pw(A_W, B_W);

    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] b_x;

    // Extending straight to PW keeps the multiply at PW bits; the true product
    // always fits, so the truncated result is exact.
    always_comb begin
        a_x = {{(PW - A_W){mode[0] & a[A_W-1]}}, a};
        b_x = {{(PW - B_W){mode[1] & b[B_W-1]}}, b};
        p   = a_x * b_x;
    end

endmodule

// File: rtl/gsm_mul_pipe.sv
// Pipelined GSM multiplier with per-transaction signedness, clock enable, valid
// chain and arithmetic post-shift. Define GSM_MUL_SAT_EN for saturating output with ovf.
module gsm_mul_pipe
    import gsm_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 15,
    parameter int dout_WIDTH = 31,
    parameter int SHIFT      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_vld,
    input  logic [1:0]            mode,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_vld,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW   = gsm_mul_pw(din0_WIDTH, din1_WIDTH);
    localparam int NDLY = (NUM_STAGE > 2) ? NUM_STAGE - 2 : 0;

    if (NUM_STAGE < GSM_MUL_STAGE_MIN || NUM_STAGE > GSM_MUL_STAGE_MAX) begin : g_bad_stage
        $error("gsm_mul_pipe %0d: NUM_STAGE=%0d outside %0d..%0d",
               ID, NUM_STAGE, GSM_MUL_STAGE_MIN, GSM_MUL_STAGE_MAX);
    end
    if (SHIFT < 0 || SHIFT > din0_WIDTH + din1_WIDTH) begin : g_bad_shift
        $error("gsm_mul_pipe %0d: SHIFT=%0d outside 0..%0d",
               ID, SHIFT, din0_WIDTH + din1_WIDTH);
    end

    logic [din0_WIDTH-1:0] a_mul;
    logic [din1_WIDTH-1:0] b_mul;
    logic [1:0]            mode_mul;
    logic                  vld_mul;
    logic signed [PW-1:0]  prod_mul;
    logic signed [PW-1:0]  prod_fin;
    logic                  vld_fin;

    // ---- stage p1: operand/mode/valid capture (bypassed for a single-stage pipe)
    if (NUM_STAGE == 1) begin : g_in_comb
        assign a_mul    = din0;
        assign b_mul    = din1;
        assign mode_mul = mode;
        assign vld_mul  = in_vld;
    end else begin : g_in_reg
        logic [din0_WIDTH-1:0] a_p1_q, a_p1_d;
        logic [din1_WIDTH-1:0] b_p1_q, b_p1_d;
        logic [1:0]            mode_p1_q, mode_p1_d;
        logic                  vld_p1_q, vld_p1_d;

        always_comb begin
            a_p1_d    = a_p1_q;
            b_p1_d    = b_p1_q;
            mode_p1_d = mode_p1_q;
            vld_p1_d  = vld_p1_q;
            if (ce) begin
                a_p1_d    = din0;
                b_p1_d    = din1;
                mode_p1_d = mode;
                vld_p1_d  = in_vld;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                a_p1_q    <= '0;
                b_p1_q    <= '0;
                mode_p1_q <= '0;
                vld_p1_q  <= 1'b0;
            end else begin
                a_p1_q    <= a_p1_d;
                b_p1_q    <= b_p1_d;
                mode_p1_q <= mode_p1_d;
                vld_p1_q  <= vld_p1_d;
            end
        end

        assign a_mul    = a_p1_q;
        assign b_mul    = b_p1_q;
        assign mode_mul = mode_p1_q;
        assign vld_mul  = vld_p1_q;
    end

    gsm_mul_core #(
        .A_W (din0_WIDTH),
        .B_W (din1_WIDTH)
    ) u_core (
        .a    (a_mul),
        .b    (b_mul),
        .mode (mode_mul),
        .p    (prod_mul)
    );

    // ---- stage p2: product delay line, NUM_STAGE-2 registers deep
    if (NDLY == 0) begin : g_no_dly
        assign prod_fin = prod_mul;
        assign vld_fin  = vld_mul;
    end else begin : g_dly
        logic [NDLY-1:0][PW-1:0] prod_p2_q, prod_p2_d;
        logic [NDLY-1:0]         vld_p2_q, vld_p2_d;

        always_comb begin
            prod_p2_d = prod_p2_q;
            vld_p2_d  = vld_p2_q;
            if (ce) begin
                prod_p2_d[0] = prod_mul;
                vld_p2_d[0]  = vld_mul;
                for (int i = 1; i < NDLY; i++) begin
                    prod_p2_d[i] = prod_p2_q[i-1];
                    vld_p2_d[i]  = vld_p2_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                prod_p2_q <= '0;
                vld_p2_q  <= '0;
            end else begin
                prod_p2_q <= prod_p2_d;
                vld_p2_q  <= vld_p2_d;
            end
        end

        assign prod_fin = prod_p2_q[NDLY-1];
        assign vld_fin  = vld_p2_q[NDLY-1];
    end

`ifdef GSM_MUL_SAT_EN
    localparam int EW = ((PW > dout_WIDTH) ? PW : dout_WIDTH) + 1;
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW - dout_WIDTH + 1){1'b0}}, {(dout_WIDTH - 1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW - dout_WIDTH + 1){1'b1}}, {(dout_WIDTH - 1){1'b0}}};

    // Returns {clamped, value}; the shifted product is widened first so the
    // range compare is exact whichever of PW and dout_WIDTH is larger.
    function automatic logic [dout_WIDTH:0] shift_sat(input logic signed [PW-1:0] p);
        logic signed [EW-1:0] v;
        v = EW'(p >>> SHIFT);
        if (v > SAT_MAX) return {1'b1, SAT_MAX[dout_WIDTH-1:0]};
        if (v < SAT_MIN) return {1'b1, SAT_MIN[dout_WIDTH-1:0]};
        return {1'b0, v[dout_WIDTH-1:0]};
    endfunction
`else
    function automatic logic [dout_WIDTH-1:0] shift_wrap(input logic signed [PW-1:0] p);
        return dout_WIDTH'(p >>> SHIFT);
    endfunction
`endif

    logic                  out_vld_q, out_vld_d;
    logic [dout_WIDTH-1:0] dout_q, dout_d;
`ifdef GSM_MUL_SAT_EN
    logic                  ovf_q, ovf_d;
    logic                  sat_hit;
`endif

    // ---- stage out: shift, narrow and (optionally) clamp into the output register
    always_comb begin
        out_vld_d = out_vld_q;
        dout_d    = dout_q;
`ifdef GSM_MUL_SAT_EN
        ovf_d     = ovf_q;
        sat_hit   = 1'b0;
`endif
        if (ce) begin
            out_vld_d = vld_fin;
`ifdef GSM_MUL_SAT_EN
            {sat_hit, dout_d} = shift_sat(prod_fin);
            ovf_d = sat_hit & vld_fin;
`else
            dout_d = shift_wrap(prod_fin);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            dout_q    <= '0;
`ifdef GSM_MUL_SAT_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            out_vld_q <= out_vld_d;
            dout_q    <= dout_d;
`ifdef GSM_MUL_SAT_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign out_vld = out_vld_q;
    assign dout    = dout_q;
`ifdef GSM_MUL_SAT_EN
    assign ovf     = ovf_q;
`else
    assign ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_gsm_mul_pipe.sv
// Self-checking bench for gsm_mul_pipe: five differently configured instances
// share clock, reset and ce; a cycle-stamped scoreboard checks data and latency.
module tb_gsm_mul_pipe;
    import gsm_mul_pkg::*;

    localparam int NDUT = 5;
    // 0: legacy 16/15/31 NS3, 1: 8/8/18 NS3, 2: 8/8/18 NS1, 3: 8/8/18 NS8 SHIFT3, 4: 16/16/16 NS3 SHIFT15
    localparam int NS_P [NDUT] = '{3, 3, 1, 8, 3};
    localparam int WA_P [NDUT] = '{16, 8, 8, 8, 16};
    localparam int WB_P [NDUT] = '{15, 8, 8, 8, 16};
    localparam int DW_P [NDUT] = '{31, 18, 18, 18, 16};
    localparam int SH_P [NDUT] = '{0, 0, 0, 3, 15};

    typedef struct {
        logic [63:0] val;
        logic        ovf;
        int          due;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] d0;
        logic [14:0] d1;
        logic [30:0] exp_wrap;
        logic [30:0] exp_sat;
        logic        ovf_sat;
    } vec_t;

    logic clk = 1'b0;
    logic reset, ce;

    logic        vld_a, vld_e, vld_s;
    logic [1:0]  mode_a, mode_e, mode_s;
    logic [15:0] d0_a, d0_s, d1_s;
    logic [14:0] d1_a;
    logic [7:0]  d0_e, d1_e;

    logic        ov_a, ov_b, ov_c, ov_d, ov_s;
    logic        ovf_a, ovf_b, ovf_c, ovf_d, ovf_s;
    logic [30:0] dout_a;
    logic [17:0] dout_b, dout_c, dout_d;
    logic [15:0] dout_s;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t        sbq [NDUT][$];
    logic        hand_use [NDUT];
    logic [63:0] hand_val [NDUT];
    logic        hand_ovf [NDUT];
    logic        last_v [NDUT];
    logic [63:0] last_d [NDUT];
    logic        last_o [NDUT];

    vec_t        tbl [9];
    logic [1:0]  sweep_mode [4];
    logic [17:0] sweep_exp [4];

    always #5 clk = ~clk;

    gsm_mul_pipe #(.ID(0), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(15), .dout_WIDTH(31), .SHIFT(0)) u_a (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(vld_a), .mode(mode_a), .din0(d0_a), .din1(d1_a),
        .out_vld(ov_a), .dout(dout_a), .ovf(ovf_a));
    gsm_mul_pipe #(.ID(1), .NUM_STAGE(3), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(18), .SHIFT(0)) u_b (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(vld_e), .mode(mode_e), .din0(d0_e), .din1(d1_e),
        .out_vld(ov_b), .dout(dout_b), .ovf(ovf_b));
    gsm_mul_pipe #(.ID(2), .NUM_STAGE(1), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(18), .SHIFT(0)) u_c (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(vld_e), .mode(mode_e), .din0(d0_e), .din1(d1_e),
        .out_vld(ov_c), .dout(dout_c), .ovf(ovf_c));
    gsm_mul_pipe #(.ID(3), .NUM_STAGE(8), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(18), .SHIFT(3)) u_d (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(vld_e), .mode(mode_e), .din0(d0_e), .din1(d1_e),
        .out_vld(ov_d), .dout(dout_d), .ovf(ovf_d));
    gsm_mul_pipe #(.ID(4), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(16), .SHIFT(15)) u_s (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(vld_s), .mode(mode_s), .din0(d0_s), .din1(d1_s),
        .out_vld(ov_s), .dout(dout_s), .ovf(ovf_s));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Integer reference: extend, multiply, floor-shift, then clamp or wrap.
    function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input int wa,
                                          input int wb, input int dw, input int sh, input logic [1:0] m);
        longint av, bv, ps;
        logic        o;
        logic [63:0] mask, r;
        o  = 1'b0;
        av = longint'(a);
        bv = longint'(b);
        if (m[0] && a[wa-1]) av = av - (longint'(1) <<< wa);
        if (m[1] && b[wb-1]) bv = bv - (longint'(1) <<< wb);
        ps = (av * bv) >>> sh;
`ifdef GSM_MUL_SAT_EN
        if (ps > (longint'(1) <<< (dw - 1)) - 1) begin
            ps = (longint'(1) <<< (dw - 1)) - 1;
            o  = 1'b1;
        end else if (ps < -(longint'(1) <<< (dw - 1))) begin
            ps = -(longint'(1) <<< (dw - 1));
            o  = 1'b1;
        end
`endif
        mask = (64'd1 << dw) - 64'd1;
        r    = ps;
        return {o, r & mask};
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic rand_inputs(input logic force_vld);
        vld_a  = force_vld | ($urandom_range(0, 3) != 0);
        mode_a = 2'($urandom_range(0, 3));
        d0_a   = pick16();
        d1_a   = 15'(pick16());
        vld_e  = force_vld | ($urandom_range(0, 3) != 0);
        mode_e = 2'($urandom_range(0, 3));
        d0_e   = 8'(pick16() >> 8);
        d1_e   = 8'(pick16() >> 8);
        vld_s  = force_vld | ($urandom_range(0, 3) != 0);
        mode_s = 2'($urandom_range(0, 3));
        d0_s   = pick16();
        d1_s   = pick16();
    endtask

    task automatic idle_inputs();
        vld_a = 1'b0;
        vld_e = 1'b0;
        vld_s = 1'b0;
    endtask

    // One clock: record accepted transactions, step the edge, then check every DUT.
    task automatic tick();
        logic [63:0] a_in [NDUT];
        logic [63:0] b_in [NDUT];
        logic [1:0]  m_in [NDUT];
        logic        v_in [NDUT];
        logic [63:0] od [NDUT];
        logic        ov [NDUT];
        logic        oo [NDUT];
        logic [64:0] r;
        logic        was_rst, was_ce, ev;
        exp_t        e;

        a_in[0] = 64'(d0_a); b_in[0] = 64'(d1_a); m_in[0] = mode_a; v_in[0] = vld_a;
        for (int i = 1; i < 4; i++) begin
            a_in[i] = 64'(d0_e); b_in[i] = 64'(d1_e); m_in[i] = mode_e; v_in[i] = vld_e;
        end
        a_in[4] = 64'(d0_s); b_in[4] = 64'(d1_s); m_in[4] = mode_s; v_in[4] = vld_s;
        was_rst = reset;
        was_ce  = ce;

        for (int i = 0; i < NDUT; i++) begin
            if (!was_rst && was_ce && v_in[i]) begin
                if (hand_use[i]) r = {hand_ovf[i], hand_val[i]};
                else r = model(a_in[i], b_in[i], WA_P[i], WB_P[i], DW_P[i], SH_P[i], m_in[i]);
                e.val = r[63:0];
                e.ovf = r[64];
                e.due = cyc + NS_P[i];
                sbq[i].push_back(e);
            end
            hand_use[i] = 1'b0;
        end

        @(posedge clk);
        #1;
        if (!was_rst && was_ce) cyc++;

        od[0] = 64'(dout_a); ov[0] = ov_a; oo[0] = ovf_a;
        od[1] = 64'(dout_b); ov[1] = ov_b; oo[1] = ovf_b;
        od[2] = 64'(dout_c); ov[2] = ov_c; oo[2] = ovf_c;
        od[3] = 64'(dout_d); ov[3] = ov_d; oo[3] = ovf_d;
        od[4] = 64'(dout_s); ov[4] = ov_s; oo[4] = ovf_s;

        for (int i = 0; i < NDUT; i++) begin
            if (was_rst) begin
                chk($sformatf("u%0d_rst_vld", i), 64'(ov[i]), 64'd0);
                chk($sformatf("u%0d_rst_dout", i), od[i], 64'd0);
                chk($sformatf("u%0d_rst_ovf", i), 64'(oo[i]), 64'd0);
                sbq[i].delete();
                last_v[i] = 1'b0;
                last_d[i] = '0;
                last_o[i] = 1'b0;
            end else if (was_ce) begin
                ev    = 1'b0;
                e.val = '0;
                e.ovf = 1'b0;
                e.due = 0;
                if (sbq[i].size() > 0 && sbq[i][0].due == cyc) begin
                    e  = sbq[i].pop_front();
                    ev = 1'b1;
                end
                chk($sformatf("u%0d_out_vld@%0d", i, cyc), 64'(ov[i]), 64'(ev));
                if (ev) chk($sformatf("u%0d_dout@%0d", i, cyc), od[i], e.val);
                chk($sformatf("u%0d_ovf@%0d", i, cyc), 64'(oo[i]), 64'(ev & e.ovf));
                last_v[i] = ev;
                last_d[i] = e.val;
                last_o[i] = ev & e.ovf;
            end else begin
                chk($sformatf("u%0d_stall_vld", i), 64'(ov[i]), 64'(last_v[i]));
                if (last_v[i]) chk($sformatf("u%0d_stall_dout", i), od[i], last_d[i]);
                chk($sformatf("u%0d_stall_ovf", i), 64'(oo[i]), 64'(last_o[i]));
            end
        end
    endtask

    initial begin
        tbl[0] = '{GSM_MUL_SU, 16'h8000, 15'h7FFF, 31'h4000_8000, 31'h4000_8000, 1'b0};
        tbl[1] = '{GSM_MUL_UU, 16'hFFFF, 15'h7FFF, 31'h7FFE_8001, 31'h3FFF_FFFF, 1'b1};
        tbl[2] = '{GSM_MUL_SS, 16'hFFFF, 15'h7FFF, 31'h0000_0001, 31'h0000_0001, 1'b0};
        tbl[3] = '{GSM_MUL_US, 16'h0002, 15'h7FFF, 31'h7FFF_FFFE, 31'h7FFF_FFFE, 1'b0};
        tbl[4] = '{GSM_MUL_SS, 16'h8000, 15'h4000, 31'h2000_0000, 31'h2000_0000, 1'b0};
        tbl[5] = '{GSM_MUL_SU, 16'h0003, 15'h0005, 31'h0000_000F, 31'h0000_000F, 1'b0};
        tbl[6] = '{GSM_MUL_SS, 16'h7FFF, 15'h3FFF, 31'h1FFF_4001, 31'h1FFF_4001, 1'b0};
        tbl[7] = '{GSM_MUL_UU, 16'h0000, 15'h1234, 31'h0000_0000, 31'h0000_0000, 1'b0};
        tbl[8] = '{GSM_MUL_SU, 16'hFFFF, 15'h7FFF, 31'h7FFF_8001, 31'h7FFF_8001, 1'b0};
        sweep_mode = '{GSM_MUL_UU, GSM_MUL_SU, GSM_MUL_US, GSM_MUL_SS};
        sweep_exp  = '{18'h0FE01, 18'h3FF01, 18'h3FF01, 18'h00001};

        for (int i = 0; i < NDUT; i++) hand_use[i] = 1'b0;
        reset = 1'b1;
        ce    = 1'b1;
        idle_inputs();
        mode_a = '0; mode_e = '0; mode_s = GSM_MUL_SS;
        d0_a = '0; d1_a = '0; d0_e = '0; d1_e = '0; d0_s = '0; d1_s = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Directed vectors: legacy table, FF x FF mode sweep, saturation corners.
        for (int i = 0; i < 9; i++) begin
            vld_a = 1'b1; mode_a = tbl[i].mode; d0_a = tbl[i].d0; d1_a = tbl[i].d1;
            hand_use[0] = 1'b1;
`ifdef GSM_MUL_SAT_EN
            hand_val[0] = 64'(tbl[i].exp_sat); hand_ovf[0] = tbl[i].ovf_sat;
`else
            hand_val[0] = 64'(tbl[i].exp_wrap); hand_ovf[0] = 1'b0;
`endif
            vld_e = (i < 4);
            if (i < 4) begin
                mode_e = sweep_mode[i]; d0_e = 8'hFF; d1_e = 8'hFF;
                hand_use[1] = 1'b1; hand_val[1] = 64'(sweep_exp[i]); hand_ovf[1] = 1'b0;
                hand_use[2] = 1'b1; hand_val[2] = 64'(sweep_exp[i]); hand_ovf[2] = 1'b0;
            end
            vld_s = (i < 3);
            mode_s = GSM_MUL_SS;
            hand_use[4] = 1'b1; hand_ovf[4] = 1'b0;
            case (i)
                0: begin
                    d0_s = 16'h8000; d1_s = 16'h8000;
`ifdef GSM_MUL_SAT_EN
                    hand_val[4] = 64'h7FFF; hand_ovf[4] = 1'b1;
`else
                    hand_val[4] = 64'h8000;
`endif
                end
                1: begin d0_s = 16'h4000; d1_s = 16'h4000; hand_val[4] = 64'h2000; end
                2: begin d0_s = 16'h8000; d1_s = 16'h7FFF; hand_val[4] = 64'h8001; end
                default: hand_use[4] = 1'b0;
            endcase
            tick();
        end
        idle_inputs();
        repeat (10) tick();

        // Clock-enable stall in the middle of four back-to-back transactions.
        for (int i = 0; i < 9; i++) begin
            ce = !(i >= 2 && i < 7);
            rand_inputs(1'b1);
            tick();
        end
        ce = 1'b1;
        idle_inputs();
        repeat (10) tick();

        // Reset while three transactions are in flight; ce low shows reset priority.
        repeat (3) begin
            rand_inputs(1'b1);
            tick();
        end
        reset = 1'b1;
        ce    = 1'b0;
        rand_inputs(1'b1);
        tick();
        reset = 1'b0;
        ce    = 1'b1;
        idle_inputs();
        repeat (10) tick();

        // Random mixed-mode stream with occasional stalls.
        repeat (300) begin
            ce = ($urandom_range(0, 7) != 0);
            rand_inputs(1'b0);
            tick();
        end
        ce = 1'b1;
        idle_inputs();
        repeat (12) tick();

        for (int i = 0; i < NDUT; i++)
            chk($sformatf("u%0d_drained", i), 64'(sbq[i].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
